id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  Decode-to-execute pipeline register with a 2-entry skid buffer for the RV32I integer core.
//  - Captures decoded ops and register-file operands.
//  - Resolves the immediate-vs-rs2 selection for operand B.
//  - Applies EX/MEM and MEM/WB forwarding.
//  - Presents resolved RS1/RS2 data and FUNC3 to the execute units (ALU, SLT compare, shifter).
//  - Registered IN_READY, so back-pressure from execute does not form a combinational path into decode.
// PARAMETERS
//  XLEN        32  operand/data width
//  REG_ADDR_W  5   register index width
// PORTS
//  CLK           in   1           core clock, all state on rising edge
//  RESET_N       in   1           synchronous, active-low reset
//  FLUSH         in   1           kill all held entries (branch/trap redirect)
//  IN_VALID      in   1           decode offers an op
//  IN_READY      out  1           stage can accept an op this cycle
//  IN_PC         in   XLEN        PC of offered op
//  IN_OPCODE     in   7           RV32I opcode
//  IN_FUNC3      in   3           funct3
//  IN_RD         in   REG_ADDR_W  destination register
//  IN_RS1        in   REG_ADDR_W  source register 1 index
//  IN_RS2        in   REG_ADDR_W  source register 2 index
//  IN_RS1_DATA   in   XLEN        register-file read, port 1
//  IN_RS2_DATA   in   XLEN        register-file read, port 2
//  IN_IMM        in   XLEN        sign-extended immediate
//  EXMEM_WE      in   1           EX/MEM result will be written back
//  EXMEM_RD      in   REG_ADDR_W  EX/MEM destination
//  EXMEM_DATA    in   XLEN        EX/MEM result
//  MEMWB_WE      in   1           MEM/WB writes the register file this cycle
//  MEMWB_RD      in   REG_ADDR_W  MEM/WB destination
//  MEMWB_DATA    in   XLEN        MEM/WB result
//  OUT_VALID     out  1           head entry valid to execute
//  OUT_READY     in   1           execute consumes the head entry
//  OUT_PC        out  XLEN        head entry PC
//  OUT_OPCODE    out  7           head entry opcode
//  OUT_FUNC3     out  3           head entry funct3 (drives execute-unit FUNC3)
//  OUT_RD        out  REG_ADDR_W  head entry destination
//  OUT_RS1_DATA  out  XLEN        forwarded operand A
//  OUT_RS2_DATA  out  XLEN        operand B: IN_IMM if OP-IMM, else forwarded rs2
// BEHAVIOUR
//  - Reset (RESET_N=0 at edge): main and skid entries invalid.
//    OUT_VALID=0, IN_READY=1, all OUT_* data = 0.
//  - Transfer rules:
//    - input handshake = IN_VALID & IN_READY
//    - output handshake = OUT_VALID & OUT_READY
//    - latency: accepted op appears on OUT_* the next cycle
//    - full throughput: 1 op/cycle when OUT_READY=1
//  - Buffer states: EMPTY (no entry), ONE (main valid), FULL (main + skid valid).
//    - EMPTY + accept                  -> ONE
//    - ONE + accept & ~consume         -> FULL
//    - ONE + consume & ~accept         -> EMPTY
//    - ONE + accept & consume          -> ONE (new op becomes main)
//    - FULL + consume                  -> ONE (skid moves to main)
//    - FULL is the only state with IN_READY=0; IN_VALID ignored there
//  - OUT_* fields are stable while OUT_VALID=1 & OUT_READY=0; only forwarded data may change.
//  - Operand B select: USE_IMM = (IN_OPCODE==7'b0010011), stored per entry.
//    - USE_IMM=1: stored B = IN_IMM, no rs2 forwarding applied.
//  - Capture bypass: if MEMWB_WE & MEMWB_RD==IN_RSx & IN_RSx!=0, store MEMWB_DATA instead of IN_RSx_DATA.
//  - Hold snoop: each cycle, held entry operands whose RSx matches a MEMWB write (RSx!=0) are overwritten with MEMWB_DATA.
//  - Output forwarding (combinational from head entry), priority order:
//    1. EXMEM_WE & EXMEM_RD==RSx & RSx!=0 -> EXMEM_DATA
//    2. MEMWB match                        -> MEMWB_DATA
//    3. otherwise                          -> stored operand
//  - x0: RSx==0 never forwards; operand reads as stored value (register file returns 0).
//  - FLUSH=1 at edge: both entries invalidated; an op offered that cycle is dropped. FLUSH has priority over accept/consume.
//  - RESET_N=0 mid-stream: same as FLUSH plus data clear; reset dominates FLUSH.
// STRUCTURE
//  - Shared package core_pkg:
//    - OPC_OP_IMM=7'b0010011, OPC_OP=7'b0110011
//    - XLEN, REG_ADDR_W
//    - typedef struct id_ex_entry_t {pc, opcode, func3, rd, rs1, rs2, use_imm, a, b}
//  - One sub-module ex_fwd_mux: resolves a single operand from stored data, RSx, and the EXMEM/MEMWB ports.
//    Instantiated twice (A, B); the B instance is bypassed when use_imm=1.
// TESTING
//  1. Reset, then IN_VALID=1 OPC_OP func3=3'b010 rs1=x1 (DATA 0xFFFFFFFF), rs2=x2 (DATA 1), OUT_READY=1
//     -> next cycle OUT_VALID=1, OUT_RS1_DATA=0xFFFFFFFF, OUT_RS2_DATA=1, OUT_FUNC3=3'b010.
//  2. OUT_READY=0, three back-to-back ops
//     -> IN_READY=0 after 2nd accept; 3rd held at input.
//     OUT_READY=1
//     -> ops emerge in order, no loss/dup.
//  3. Head rs1=x5, EXMEM_WE=1 EXMEM_RD=5 EXMEM_DATA=0x10, MEMWB_WE=1 MEMWB_RD=5 MEMWB_DATA=0x20
//     -> OUT_RS1_DATA=0x10; drop EXMEM -> 0x20.
//  4. OPC_OP_IMM, IN_IMM=0xFFFFF800, rs2=x3, EXMEM_RD=3 writing
//     -> OUT_RS2_DATA=0xFFFFF800.
//  5. FULL state + FLUSH=1 with IN_VALID=1
//     -> next cycle OUT_VALID=0, IN_READY=1; flushed op never appears.
//  6. Held entry rs1=x7, single MEMWB write x7=0xABCD then MEMWB_WE=0, OUT_READY later 1
//     -> OUT_RS1_DATA=0xABCD; rd=0 forwarding sources never alter x0 operand.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: widths, opcodes, the ID/EX entry record and
// the register-hit/snoop helpers used by the operand stage.
package core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [6:0]            opcode;
        logic [2:0]            func3;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_imm;
        logic [XLEN-1:0]       a;
        logic [XLEN-1:0]       b;
    } id_ex_entry_t;

    // x0 is hardwired, so a write targeting it never counts as a hit
    function automatic logic reg_hit(input logic                  we,
                                     input logic [REG_ADDR_W-1:0] wr_rd,
                                     input logic [REG_ADDR_W-1:0] rs);
        return we && (wr_rd == rs) && (rs != '0);
    endfunction

    function automatic id_ex_entry_t snoop(input id_ex_entry_t          e,
                                           input logic                  we,
                                           input logic [REG_ADDR_W-1:0] wr_rd,
                                           input logic [XLEN-1:0]       wr_data);
        id_ex_entry_t r;
        r = e;
        if (reg_hit(we, wr_rd, e.rs1)) r.a = wr_data;
        if (!e.use_imm && reg_hit(we, wr_rd, e.rs2)) r.b = wr_data;
        return r;
    endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// Resolves one execute operand: EX/MEM result first, then MEM/WB, else the
// value held in the pipeline entry.
module ex_fwd_mux
    import core_pkg::*;
(
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [XLEN-1:0]       stored,
    input  logic                  exmem_we,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_data,
    input  logic                  memwb_we,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_data,
    output logic [XLEN-1:0]       data
);

    always_comb begin
        data = stored;
        if (en) begin
            if (reg_hit(exmem_we, exmem_rd, rs)) begin
                data = exmem_data;
            end else if (reg_hit(memwb_we, memwb_rd, rs)) begin
                data = memwb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with a 2-entry skid buffer, operand-B select and
// EX/MEM + MEM/WB forwarding toward the execute units.
module id_ex_operand_stage
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_func3,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  exmem_we,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_data,
    input  logic                  memwb_we,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_func3,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]       out_rs1_data,
    output logic [XLEN-1:0]       out_rs2_data
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} buf_state_t;

    buf_state_t   state_q, state_d;
    id_ex_entry_t main_q, main_d;
    id_ex_entry_t skid_q, skid_d;
    id_ex_entry_t new_entry, main_snoop, skid_snoop;
    logic         accept, consume;

    // in_ready depends only on the state register, never on out_ready
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        new_entry.pc      = in_pc;
        new_entry.opcode  = in_opcode;
        new_entry.func3   = in_func3;
        new_entry.rd      = in_rd;
        new_entry.rs1     = in_rs1;
        new_entry.rs2     = in_rs2;
        new_entry.use_imm = (in_opcode == OPC_OP_IMM);
        new_entry.a       = reg_hit(memwb_we, memwb_rd, in_rs1) ? memwb_data : in_rs1_data;
        if (new_entry.use_imm) begin
            new_entry.b = in_imm;
        end else begin
            new_entry.b = reg_hit(memwb_we, memwb_rd, in_rs2) ? memwb_data : in_rs2_data;
        end
    end

    assign main_snoop = snoop(main_q, memwb_we, memwb_rd, memwb_data);
    assign skid_snoop = snoop(skid_q, memwb_we, memwb_rd, memwb_data);

    always_comb begin
        state_d = state_q;
        main_d  = main_snoop;
        skid_d  = skid_snoop;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = new_entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && !consume) begin
                    skid_d  = new_entry;
                    state_d = StFull;
                end else if (!accept && consume) begin
                    state_d = StEmpty;
                end else if (accept && consume) begin
                    main_d = new_entry;
                end
            end
            StFull: begin
                if (consume) begin
                    main_d  = skid_snoop;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) state_d = StEmpty;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_pc     = main_q.pc;
    assign out_opcode = main_q.opcode;
    assign out_func3  = main_q.func3;
    assign out_rd     = main_q.rd;

    ex_fwd_mux u_fwd_a (
        .en         (1'b1),
        .rs         (main_q.rs1),
        .stored     (main_q.a),
        .exmem_we   (exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_we   (memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .data       (out_rs1_data)
    );

    // Immediate operands pass through untouched
    ex_fwd_mux u_fwd_b (
        .en         (!main_q.use_imm),
        .rs         (main_q.rs2),
        .stored     (main_q.b),
        .exmem_we   (exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_we   (memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .data       (out_rs2_data)
    );

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: skid buffering, operand select,
// forwarding priority, snooping, flush and reset.
module tb_id_ex_operand_stage;
    import core_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n, flush, in_valid, in_ready;
    logic [XLEN-1:0]       in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [6:0]            in_opcode;
    logic [2:0]            in_func3;
    logic [REG_ADDR_W-1:0] in_rd, in_rs1, in_rs2;
    logic                  exmem_we, memwb_we;
    logic [REG_ADDR_W-1:0] exmem_rd, memwb_rd;
    logic [XLEN-1:0]       exmem_data, memwb_data;
    logic                  out_valid, out_ready;
    logic [XLEN-1:0]       out_pc, out_rs1_data, out_rs2_data;
    logic [6:0]            out_opcode;
    logic [2:0]            out_func3;
    logic [REG_ADDR_W-1:0] out_rd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_opcode    (in_opcode),
        .in_func3     (in_func3),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_imm       (in_imm),
        .exmem_we     (exmem_we),
        .exmem_rd     (exmem_rd),
        .exmem_data   (exmem_data),
        .memwb_we     (memwb_we),
        .memwb_rd     (memwb_rd),
        .memwb_data   (memwb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_func3    (out_func3),
        .out_rd       (out_rd),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] pc, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_opcode   = opc;
        in_func3    = f3;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        vectors++;
        if ({out_pc, out_opcode, out_func3, out_rd} !== '0) begin
            miscompares++; $display("FAIL reset_fields: got pc=%h opc=%h f3=%h rd=%h expected 0",
                                    out_pc, out_opcode, out_func3, out_rd);
        end
        vectors++;
        if ({out_rs1_data, out_rs2_data} !== 64'h0) begin
            miscompares++; $display("FAIL reset_data: got %h/%h expected 0/0",
                                    out_rs1_data, out_rs2_data);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        drive_op(32'h1000, OPC_OP, 3'b010, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'h1, 32'h0);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_valid: got %b expected 1", out_valid);
        end
        vectors++;
        if (out_rs1_data !== 32'hFFFF_FFFF || out_rs2_data !== 32'h1) begin
            miscompares++; $display("FAIL basic_data: got %h/%h expected ffffffff/00000001",
                                    out_rs1_data, out_rs2_data);
        end
        vectors++;
        if (out_func3 !== 3'b010 || out_pc !== 32'h1000 || out_rd !== 5'd3) begin
            miscompares++; $display("FAIL basic_fields: got f3=%b pc=%h rd=%0d expected 010/1000/3",
                                    out_func3, out_pc, out_rd);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        drive_op(32'h100, OPC_OP, 3'b000, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h0);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_ready_empty: got %b expected 1", in_ready);
        end
        step();
        drive_op(32'h104, OPC_OP, 3'b000, 5'd2, 5'd0, 5'd0, 32'h104, 32'h0, 32'h0);
        step();
        vectors++;
        if (in_ready !== 1'b0 || out_pc !== 32'h100) begin
            miscompares++; $display("FAIL b2b_full: got ready=%b pc=%h expected 0/100",
                                    in_ready, out_pc);
        end
        drive_op(32'h108, OPC_OP, 3'b000, 5'd3, 5'd0, 5'd0, 32'h108, 32'h0, 32'h0);
        step();
        vectors++;
        if (in_ready !== 1'b0 || out_pc !== 32'h100 || out_rd !== 5'd1) begin
            miscompares++; $display("FAIL b2b_hold: got ready=%b pc=%h rd=%0d expected 0/100/1",
                                    in_ready, out_pc, out_rd);
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_pc !== 32'h104 || out_rs1_data !== 32'h104 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_second: got pc=%h a=%h ready=%b expected 104/104/1",
                                    out_pc, out_rs1_data, in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_rd !== 5'd3) begin
            miscompares++; $display("FAIL b2b_third: got v=%b pc=%h rd=%0d expected 1/108/3",
                                    out_valid, out_pc, out_rd);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_forward;
        out_ready = 1'b0;
        drive_op(32'h200, OPC_OP, 3'b000, 5'd4, 5'd5, 5'd6, 32'h55, 32'h66, 32'h0);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_rs1_data !== 32'h55) begin
            miscompares++; $display("FAIL fwd_none: got %h expected 55", out_rs1_data);
        end
        exmem_we = 1'b1; exmem_rd = 5'd5; exmem_data = 32'h10;
        memwb_we = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h20;
        #1;
        vectors++;
        if (out_rs1_data !== 32'h10) begin
            miscompares++; $display("FAIL fwd_exmem_prio: got %h expected 10", out_rs1_data);
        end
        exmem_we = 1'b0;
        #1;
        vectors++;
        if (out_rs1_data !== 32'h20 || out_rs2_data !== 32'h66) begin
            miscompares++; $display("FAIL fwd_memwb: got %h/%h expected 20/66",
                                    out_rs1_data, out_rs2_data);
        end
        step();
        memwb_we = 1'b0;
        #1;
        vectors++;
        if (out_rs1_data !== 32'h20) begin
            miscompares++; $display("FAIL fwd_snooped: got %h expected 20", out_rs1_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_imm;
        out_ready = 1'b0;
        drive_op(32'h240, OPC_OP_IMM, 3'b000, 5'd8, 5'd0, 5'd3, 32'h7, 32'h33, 32'hFFFF_F800);
        exmem_we = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hDEAD;
        memwb_we = 1'b1; memwb_rd = 5'd3; memwb_data = 32'hBEEF;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_rs2_data !== 32'hFFFF_F800 || out_rs1_data !== 32'h7) begin
            miscompares++; $display("FAIL imm_select: got %h/%h expected 7/fffff800",
                                    out_rs1_data, out_rs2_data);
        end
        step();
        vectors++;
        if (out_rs2_data !== 32'hFFFF_F800 || out_opcode !== OPC_OP_IMM) begin
            miscompares++; $display("FAIL imm_hold: got %h opc=%h expected fffff800/13",
                                    out_rs2_data, out_opcode);
        end
        exmem_we = 1'b0; memwb_we = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_capture_bypass;
        memwb_we = 1'b1; memwb_rd = 5'd1; memwb_data = 32'h77;
        drive_op(32'h280, OPC_OP, 3'b000, 5'd9, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0);
        step();
        in_valid = 1'b0;
        memwb_we = 1'b0;
        #1;
        vectors++;
        if (out_rs1_data !== 32'h77 || out_rs2_data !== 32'h6) begin
            miscompares++; $display("FAIL capture_bypass: got %h/%h expected 77/6",
                                    out_rs1_data, out_rs2_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive_op(32'h300, OPC_OP, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        drive_op(32'h304, OPC_OP, 3'b000, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_pre_full: got %b expected 0", in_ready);
        end
        drive_op(32'h308, OPC_OP, 3'b000, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_full: got v=%b ready=%b expected 0/1",
                                    out_valid, in_ready);
        end
        drive_op(32'h30C, OPC_OP, 3'b000, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h30C) begin
            miscompares++; $display("FAIL flush_refill: got v=%b pc=%h expected 1/30c",
                                    out_valid, out_pc);
        end
        drive_op(32'h310, OPC_OP, 3'b000, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_drop_offered: got %b expected 0", out_valid);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_no_ghost: got v=%b pc=%h expected 0",
                                    out_valid, out_pc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_snoop;
        out_ready = 1'b0;
        drive_op(32'h400, OPC_OP, 3'b001, 5'd0, 5'd7, 5'd0, 32'h1111, 32'h2222, 32'h0);
        step();
        in_valid = 1'b0;
        memwb_we = 1'b1; memwb_rd = 5'd7; memwb_data = 32'hABCD;
        step();
        memwb_we = 1'b0;
        #1;
        vectors++;
        if (out_rs1_data !== 32'hABCD) begin
            miscompares++; $display("FAIL snoop_capture: got %h expected abcd", out_rs1_data);
        end
        step();
        vectors++;
        if (out_rs1_data !== 32'hABCD) begin
            miscompares++; $display("FAIL snoop_hold: got %h expected abcd", out_rs1_data);
        end
        exmem_we = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hBAD0_BAD0;
        memwb_we = 1'b1; memwb_rd = 5'd0; memwb_data = 32'hBAD0_BAD0;
        #1;
        vectors++;
        if (out_rs2_data !== 32'h2222 || out_rs1_data !== 32'hABCD) begin
            miscompares++; $display("FAIL x0_no_fwd: got %h/%h expected abcd/2222",
                                    out_rs1_data, out_rs2_data);
        end
        step();
        exmem_we = 1'b0; memwb_we = 1'b0;
        #1;
        vectors++;
        if (out_rs2_data !== 32'h2222) begin
            miscompares++; $display("FAIL x0_no_snoop: got %h expected 2222", out_rs2_data);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_rs1_data !== 32'hABCD || out_func3 !== 3'b001) begin
            miscompares++; $display("FAIL snoop_release: got v=%b a=%h f3=%b expected 1/abcd/001",
                                    out_valid, out_rs1_data, out_func3);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        drive_op(32'h500, OPC_OP, 3'b111, 5'd6, 5'd0, 5'd0, 32'h99, 32'h98, 32'h0);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_rs1_data !== 32'h99) begin
            miscompares++; $display("FAIL mid_reset_pre: got v=%b a=%h expected 1/99",
                                    out_valid, out_rs1_data);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_rs1_data !== 32'h0
            || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL mid_reset: got v=%b pc=%h a=%h ready=%b expected 0/0/0/1",
                                    out_valid, out_pc, out_rs1_data, in_ready);
        end
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_opcode = '0; in_func3 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        exmem_we = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_we = 1'b0; memwb_rd = '0; memwb_data = '0;

        test_reset();
        test_basic();
        test_back_to_back();
        test_forward();
        test_imm();
        test_capture_bypass();
        test_flush();
        test_snoop();
        test_reset_midstream();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
